ysyx_24110015_lsu: RTL

YSYX_24110015_LSU -- requirements
Module: ysyx_24110015_lsu

---
 rtl/ysyx_24110015_lsu_pkg.sv | 20 ++
 rtl/ysyx_24110015_ld_align.sv | 28 ++
 rtl/ysyx_24110015_lsu.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ysyx_24110015_lsu_pkg.sv
// Shared definitions for the load/store unit: data width,
// FSM state encoding and the func3 access-size encodings.
package ysyx_24110015_lsu_pkg;

    localparam int LSU_XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/ysyx_24110015_ld_align.sv
// Load data alignment: shifts the bus word down to the addressed
// byte lane, then sign/zero-extends by access size.
// Ports: i_rdata (bus word), i_addr (byte offset), i_func3, o_data.
module ysyx_24110015_ld_align
    import ysyx_24110015_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_data
);

    logic [31:0] w_sh;

    assign w_sh = i_rdata >> {i_addr, 3'b000};

    always_comb begin
        o_data = w_sh;
        case (i_func3)
            F3_B:    o_data = {{24{w_sh[7]}}, w_sh[7:0]};
            F3_H:    o_data = {{16{w_sh[15]}}, w_sh[15:0]};
            F3_BU:   o_data = {24'd0, w_sh[7:0]};
            F3_HU:   o_data = {16'd0, w_sh[15:0]};
            default: o_data = w_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit between execute and writeback. Accepts one op,
// runs at most one bus transaction, and presents the writeback result.
// Ports: in_* (execute handshake + op fields), bus_req_* / bus_rsp_*
// (memory bus), out_* / wb_* / RegWrite_o / misalign (to writeback).
module ysyx_24110015_lsu
    import ysyx_24110015_lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [2:0]      func3,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            RegWrite_i,
    input  logic [4:0]      wb_addr_i,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic [XLEN-1:0] bus_req_addr,
    output logic            bus_req_wen,
    output logic [XLEN-1:0] bus_req_wdata,
    output logic [3:0]      bus_req_wstrb,
    input  logic            bus_rsp_valid,
    input  logic [XLEN-1:0] bus_rsp_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] wb_data,
    output logic            RegWrite_o,
    output logic [4:0]      wb_addr_o,
    output logic            misalign
);

    lsu_state_e      r_state;
    lsu_state_e      w_next;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic [2:0]      r_func3;
    logic            r_mr;
    logic            r_mw;
    logic            r_rw;
    logic [4:0]      r_wbaddr;
    logic            r_mis;

    logic            w_accept;
    logic            w_mem;
    logic            w_half;
    logic            w_mis;
    logic [XLEN-1:0] w_ld;
    logic [3:0]      w_strb;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_mem    = MemRead | MemWrite;
    assign w_half   = (func3 == F3_H) || (func3 == F3_HU);
    // Only real memory ops can fault; ALU results ignore alignment.
    assign w_mis    = w_mem &
                      ((w_half & alu_out[0]) |
                       ((func3 == F3_W) & (alu_out[1:0] != 2'b00)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_func3  <= '0;
            r_mr     <= 1'b0;
            r_mw     <= 1'b0;
            r_rw     <= 1'b0;
            r_wbaddr <= '0;
            r_mis    <= 1'b0;
        end else if (w_accept) begin
            r_addr   <= alu_out;
            r_wdata  <= mem_wdata;
            r_rdata  <= '0;
            r_func3  <= func3;
            r_mr     <= MemRead;
            r_mw     <= MemWrite;
            r_rw     <= RegWrite_i;
            r_wbaddr <= wb_addr_i;
            r_mis    <= w_mis;
        end else if (r_state == S_WAIT && bus_rsp_valid) begin
            r_rdata  <= bus_rsp_rdata;
        end
    end

    always_comb begin
        w_next        = r_state;
        in_ready      = 1'b0;
        bus_req_valid = 1'b0;
        out_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = (w_mem && !w_mis) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus_rsp_valid) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_strb = 4'b0000;
        if (r_mw) begin
            case (r_func3)
                F3_B:    w_strb = 4'b0001 << r_addr[1:0];
                F3_H:    w_strb = 4'b0011 << r_addr[1:0];
                F3_W:    w_strb = 4'b1111;
                default: w_strb = 4'b0000;
            endcase
        end
    end

    ysyx_24110015_ld_align u_ld_align (
        .i_rdata (r_rdata),
        .i_addr  (r_addr[1:0]),
        .i_func3 (r_func3),
        .o_data  (w_ld)
    );

    assign bus_req_addr  = {r_addr[XLEN-1:2], 2'b00};
    assign bus_req_wen   = r_mw;
    assign bus_req_wdata = r_wdata << {r_addr[1:0], 3'b000};
    assign bus_req_wstrb = w_strb;

    assign wb_data    = r_mr ? w_ld : (r_mw ? '0 : r_addr);
    assign RegWrite_o = r_rw & ~r_mis;
    assign wb_addr_o  = r_wbaddr;
    assign misalign   = r_mis;

endmodule
